// File: rtl/aqrui_pkg.sv
// Shared definitions for the multicycle RV32I-subset core control path.
// Holds the controller state encoding, the supported major opcodes, the
// ALU operation encodings driven to the ALU decoder, the branch funct3
// codes, and the opcode-class record produced by ctrl_opdecode.
package aqrui_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [6:0] OP_L = 7'b0000011;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // One-hot opcode class; all-zero means the opcode is not supported.
   typedef struct packed {
      logic is_i;
      logic is_r;
      logic is_s;
      logic is_b;
      logic is_l;
   } opcls_t;

   // Branch resolution from the SUB result's zero flag. Only BEQ/BNE are
   // supported; every other funct3 resolves as not taken.
   function automatic logic br_taken(input logic [2:0] funct3, input logic zero);
      return ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
   endfunction

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational major-opcode classifier, shared by the control FSM and the
// immediate-select logic.
// Ports:
//   i_opcode  instruction bits [6:0]
//   o_cls     one-hot opcode class (I-ALU, R, S, B, Load)
//   o_legal   high when the opcode belongs to one of the supported classes
module ctrl_opdecode
   import aqrui_pkg::*;
(
   input  logic [6:0] i_opcode,
   output opcls_t     o_cls,
   output logic       o_legal
);

   always_comb begin
      o_cls      = '0;
      o_cls.is_i = (i_opcode == OP_I);
      o_cls.is_r = (i_opcode == OP_R);
      o_cls.is_s = (i_opcode == OP_S);
      o_cls.is_b = (i_opcode == OP_B);
      o_cls.is_l = (i_opcode == OP_L);
      o_legal    = |o_cls;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I-subset core. Sequences the shared
// datapath through FETCH/DECODE/EXEC/MEM/WB and drives every enable/select
// strobe plus the instruction/data memory request handshakes, with a bounded
// wait counter that times out stalled requests.
// Optional feature: define AQRUI_ILLEGAL_TRAP_EN to trap unsupported opcodes
// in a sticky TRAP state (illegal_o=1); otherwise they execute as a NOP.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   instr_i            instruction register output
//   zero_i             ALU zero flag (EXEC)
//   mem_ready_i        acknowledge for the pending fetch/load/store
//   imem_req_o         instruction fetch request
//   dmem_re_o/we_o     data read / write request
//   ir_we_o, pc_we_o   IR/old-PC latch, PC update
//   pc_sel_o           0 = PC+4, 1 = old PC + immediate
//   alu_src_o          0 = rs2, 1 = immediate
//   alu_op_o           00 add, 01 sub, 10 funct-decoded
//   rf_we_o, wb_sel_o  register write, write-back source (1 = load data)
//   timeout_o          one-cycle memory timeout pulse
//   illegal_o          illegal-opcode trap flag
//   state_o            current state (debug)
module multicycle_ctrl
   import aqrui_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] instr_i,
   input  logic        zero_i,
   input  logic        mem_ready_i,
   output logic        imem_req_o,
   output logic        dmem_re_o,
   output logic        dmem_we_o,
   output logic        ir_we_o,
   output logic        pc_we_o,
   output logic        pc_sel_o,
   output logic        alu_src_o,
   output logic [1:0]  alu_op_o,
   output logic        rf_we_o,
   output logic        wb_sel_o,
   output logic        timeout_o,
   output logic        illegal_o,
   output logic [2:0]  state_o
);

   localparam int CNT_W = $clog2(WAIT_MAX);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   opcls_t           r_cls;
   logic [2:0]       r_funct3;
   opcls_t           w_cls;
   logic             w_legal;
   logic             w_req;
   logic             w_tmo;
   logic             w_unused;

   // Only the opcode and funct3 fields steer the controller.
   assign w_unused = ^{instr_i[31:15], instr_i[11:7]};

   ctrl_opdecode u_opdecode (
      .i_opcode (instr_i[6:0]),
      .o_cls    (w_cls),
      .o_legal  (w_legal)
   );

   // A request is pending in every FETCH and MEM cycle; ready wins over
   // timeout because the timeout term requires ready low.
   assign w_req = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign w_tmo = w_req && !mem_ready_i && (r_cnt == CNT_W'(WAIT_MAX - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         // Every non-waiting cycle clears the counter, so FETCH and MEM are
         // always entered (or re-entered after timeout) with a count of 0.
         if (w_req && !mem_ready_i && !w_tmo) r_cnt <= r_cnt + 1'b1;
         else                                 r_cnt <= '0;
      end
   end

   // Opcode class and funct3 are captured in DECODE so the later phases
   // do not depend on the IR staying untouched.
   always_ff @(posedge clk_i) begin
      if (r_state == ST_DECODE) begin
         r_cls    <= w_cls;
         r_funct3 <= instr_i[14:12];
      end
   end

   always_comb begin
      w_next     = r_state;
      imem_req_o = 1'b0;
      dmem_re_o  = 1'b0;
      dmem_we_o  = 1'b0;
      ir_we_o    = 1'b0;
      pc_we_o    = 1'b0;
      pc_sel_o   = 1'b0;
      alu_src_o  = 1'b0;
      alu_op_o   = ALU_ADD;
      rf_we_o    = 1'b0;
      wb_sel_o   = 1'b0;
      case (r_state)
         ST_FETCH: begin
            imem_req_o = 1'b1;
            if (mem_ready_i) begin
               ir_we_o = 1'b1;
               pc_we_o = 1'b1;
               w_next  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (w_legal) w_next = ST_EXEC;
`ifdef AQRUI_ILLEGAL_TRAP_EN
            else         w_next = ST_TRAP;
`else
            else         w_next = ST_FETCH;
`endif
         end
         ST_EXEC: begin
            w_next = ST_FETCH;
            if (r_cls.is_i || r_cls.is_r) begin
               alu_src_o = r_cls.is_i;
               alu_op_o  = ALU_FN;
               w_next    = ST_WB;
            end else if (r_cls.is_l || r_cls.is_s) begin
               alu_src_o = 1'b1;
               alu_op_o  = ALU_ADD;
               w_next    = ST_MEM;
            end else if (r_cls.is_b) begin
               alu_op_o = ALU_SUB;
               if (br_taken(r_funct3, zero_i)) begin
                  pc_we_o  = 1'b1;
                  pc_sel_o = 1'b1;
               end
            end
         end
         ST_MEM: begin
            dmem_re_o = r_cls.is_l;
            dmem_we_o = r_cls.is_s;
            if (mem_ready_i) w_next = r_cls.is_l ? ST_WB : ST_FETCH;
            else if (w_tmo)  w_next = ST_FETCH;
         end
         ST_WB: begin
            rf_we_o  = 1'b1;
            wb_sel_o = r_cls.is_l;
            w_next   = ST_FETCH;
         end
`ifdef AQRUI_ILLEGAL_TRAP_EN
         ST_TRAP: w_next = ST_TRAP;
`endif
         default: w_next = ST_FETCH;
      endcase
      // Reset kills every strobe in the same cycle it is asserted.
      if (rst_i) begin
         imem_req_o = 1'b0;
         dmem_re_o  = 1'b0;
         dmem_we_o  = 1'b0;
         ir_we_o    = 1'b0;
         pc_we_o    = 1'b0;
         pc_sel_o   = 1'b0;
         alu_src_o  = 1'b0;
         alu_op_o   = ALU_ADD;
         rf_we_o    = 1'b0;
         wb_sel_o   = 1'b0;
      end
   end

   assign timeout_o = w_tmo && !rst_i;
   assign state_o   = rst_i ? 3'd0 : r_state;
`ifdef AQRUI_ILLEGAL_TRAP_EN
   assign illegal_o = (r_state == ST_TRAP) && !rst_i;
`else
   assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (WAIT_MAX=4). Outputs are packed into
// one 16-bit word and compared cycle by cycle against hand-built strobe
// words. Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_multicycle_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] instr_i = 32'h0;
   logic        zero_i = 1'b0;
   logic        mem_ready_i = 1'b0;
   logic        imem_req_o, dmem_re_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o;
   logic        alu_src_o, rf_we_o, wb_sel_o, timeout_o, illegal_o;
   logic [1:0]  alu_op_o;
   logic [2:0]  state_o;

   int n_vec = 0;
   int n_err = 0;

   multicycle_ctrl #(.WAIT_MAX(4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .instr_i     (instr_i),
      .zero_i      (zero_i),
      .mem_ready_i (mem_ready_i),
      .imem_req_o  (imem_req_o),
      .dmem_re_o   (dmem_re_o),
      .dmem_we_o   (dmem_we_o),
      .ir_we_o     (ir_we_o),
      .pc_we_o     (pc_we_o),
      .pc_sel_o    (pc_sel_o),
      .alu_src_o   (alu_src_o),
      .alu_op_o    (alu_op_o),
      .rf_we_o     (rf_we_o),
      .wb_sel_o    (wb_sel_o),
      .timeout_o   (timeout_o),
      .illegal_o   (illegal_o),
      .state_o     (state_o)
   );

   always #5 clk_i = ~clk_i;

   logic [15:0] obs;
   assign obs = {imem_req_o, dmem_re_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o,
                 alu_src_o, alu_op_o, rf_we_o, wb_sel_o, timeout_o, illegal_o, state_o};

   localparam logic [15:0] IMEM = 16'h8000, DRE = 16'h4000, DWE = 16'h2000;
   localparam logic [15:0] IRW  = 16'h1000, PCW = 16'h0800, PCS = 16'h0400;
   localparam logic [15:0] ASRC = 16'h0200, AFN = 16'h0100, ASUB = 16'h0080;
   localparam logic [15:0] RFW  = 16'h0040, WBS = 16'h0020, TMO = 16'h0010;
   localparam logic [15:0] ILL  = 16'h0008;
   localparam logic [15:0] SD = 16'd1, SE = 16'd2, SM = 16'd3, SW = 16'd4, ST = 16'd5;
   localparam logic [15:0] FGO = IMEM | IRW | PCW;

   // Hold reset for two edges; returns at a falling edge with FETCH current.
   task automatic apply_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      mem_ready_i = 1'b0;
      zero_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      mem_ready_i = 1'b1;
      #1;
      n_vec++;
      if (obs !== 16'h0) begin
         n_err++;
         $display("FAIL reset_hold obs=%h exp=%h", obs, 16'h0);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      mem_ready_i = 1'b0;
      #1;
      n_vec++;
      if (obs !== IMEM) begin
         n_err++;
         $display("FAIL reset_first_fetch obs=%h exp=%h", obs, IMEM);
      end
   endtask

   task automatic test_alu(input logic [31:0] ins, input logic [15:0] ex_bits, input string nm);
      logic [15:0] e[5];
      logic        r[5];
      e = '{FGO, SD, ex_bits | SE, RFW | SW, IMEM};
      r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      apply_reset();
      instr_i = ins;
      for (int i = 0; i < 5; i++) begin
         mem_ready_i = r[i];
         #1;
         n_vec++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL %s cyc%0d obs=%h exp=%h", nm, i, obs, e[i]);
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_load_wait();
      logic [15:0] e[9];
      logic        r[9];
      e = '{FGO, SD, ASRC | SE, DRE | SM, DRE | SM, DRE | SM, DRE | SM, RFW | WBS | SW, IMEM};
      r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      apply_reset();
      instr_i = 32'h0000A183;
      for (int i = 0; i < 9; i++) begin
         mem_ready_i = r[i];
         #1;
         n_vec++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL lw_wait cyc%0d obs=%h exp=%h", i, obs, e[i]);
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_store(input logic ready_in_mem);
      logic [15:0] e[8];
      logic        r[8];
      int          n;
      if (ready_in_mem) begin
         e = '{FGO, SD, ASRC | SE, DWE | SM, IMEM, 16'h0, 16'h0, 16'h0};
         r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
         n = 5;
      end else begin
         e = '{FGO, SD, ASRC | SE, DWE | SM, DWE | SM, DWE | SM, DWE | TMO | SM, IMEM};
         r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         n = 8;
      end
      apply_reset();
      instr_i = 32'h0030A023;
      for (int i = 0; i < n; i++) begin
         mem_ready_i = r[i];
         #1;
         n_vec++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL sw rdy=%0b cyc%0d obs=%h exp=%h", ready_in_mem, i, obs, e[i]);
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_branch();
      logic [31:0] ins[6];
      logic        z[6];
      logic        tk[6];
      logic [15:0] e;
      ins = '{32'h00208063, 32'h00208063, 32'h00209063, 32'h00209063, 32'h0020C063, 32'h0020C063};
      z   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tk  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int k = 0; k < 6; k++) begin
         apply_reset();
         instr_i = ins[k];
         for (int i = 0; i < 4; i++) begin
            mem_ready_i = (i == 0);
            zero_i = z[k];
            case (i)
               0:       e = FGO;
               1:       e = SD;
               2:       e = tk[k] ? (ASUB | PCW | PCS | SE) : (ASUB | SE);
               default: e = IMEM;
            endcase
            #1;
            n_vec++;
            if (obs !== e) begin
               n_err++;
               $display("FAIL branch%0d cyc%0d obs=%h exp=%h", k, i, obs, e);
            end
            @(negedge clk_i);
         end
      end
   endtask

   task automatic test_fetch_timeout();
      logic [15:0] e[6];
      e = '{IMEM, IMEM, IMEM, IMEM | TMO, IMEM, FGO};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         mem_ready_i = (i == 5);
         #1;
         n_vec++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL fetch_timeout cyc%0d obs=%h exp=%h", i, obs, e[i]);
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_illegal();
`ifdef AQRUI_ILLEGAL_TRAP_EN
      logic [15:0] e[6];
      e = '{FGO, SD, ILL | ST, ILL | ST, ILL | ST, ILL | ST};
`else
      logic [15:0] e[6];
      e = '{FGO, SD, IMEM, IMEM, IMEM, IMEM | TMO};
`endif
      apply_reset();
      instr_i = 32'h0000007F;
      for (int i = 0; i < 6; i++) begin
         mem_ready_i = (i == 0);
         #1;
         n_vec++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL illegal cyc%0d obs=%h exp=%h", i, obs, e[i]);
         end
         @(negedge clk_i);
      end
      rst_i = 1'b1;
      #1;
      n_vec++;
      if (obs !== 16'h0) begin
         n_err++;
         $display("FAIL illegal_reset obs=%h exp=%h", obs, 16'h0);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      mem_ready_i = 1'b0;
      #1;
      n_vec++;
      if (obs !== IMEM) begin
         n_err++;
         $display("FAIL illegal_after_reset obs=%h exp=%h", obs, IMEM);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [15:0] e[7];
      logic        rs[7];
      e  = '{FGO, SD, ASRC | SE, DRE | SM, DRE | SM, 16'h0, IMEM};
      rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      apply_reset();
      instr_i = 32'h0000A183;
      for (int i = 0; i < 7; i++) begin
         mem_ready_i = (i == 0);
         rst_i = rs[i];
         #1;
         n_vec++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL reset_mid_lw cyc%0d obs=%h exp=%h", i, obs, e[i]);
         end
         @(negedge clk_i);
      end
   endtask

   initial begin
      test_reset();
      test_alu(32'h002081B3, AFN, "add");
      test_alu(32'h00508193, AFN | ASRC, "addi");
      test_load_wait();
      test_store(1'b1);
      test_store(1'b0);
      test_branch();
      test_fetch_timeout();
      test_illegal();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I-subset core. Sequences the shared datapath (PC, instruction register, register file, ALU, immediate sign-extender, data memory port) through fetch, decode, execute, memory and write-back phases for the five supported opcode classes: I-ALU, R, S, B and Load. Sits beside the datapath, reads the latched instruction word and ALU zero flag, and drives every enable/select strobe plus the memory request handshakes.

## Interface
- `WAIT_MAX`, default 15: maximum cycles a memory request waits for `mem_ready_i` before timeout; legal range 2..255.
- `clk_i` in 1: single clock; all state on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `instr_i` in 32: instruction register output; valid from DECODE onward.
- `zero_i` in 1: ALU zero flag, valid in EXEC.
- `mem_ready_i` in 1: memory acknowledge for the current fetch/load/store request.
- `imem_req_o` out 1: instruction fetch request.
- `dmem_re_o` out 1: data read request.
- `dmem_we_o` out 1: data write request.
- `ir_we_o` out 1: latch `instr_i` source and the instruction's PC into the IR/old-PC registers.
- `pc_we_o` out 1: PC update strobe.
- `pc_sel_o` out 1: 0 = PC+4, 1 = old PC + immediate (branch target).
- `alu_src_o` out 1: ALU operand B, 0 = rs2, 1 = sign-extended immediate.
- `alu_op_o` out 2: 00 add, 01 sub, 10 funct3/funct7-decoded by the ALU decoder.
- `rf_we_o` out 1: register file write enable.
- `wb_sel_o` out 1: write-back source, 0 = ALU result, 1 = load data.
- `timeout_o` out 1: one-cycle pulse on memory timeout.
- `illegal_o` out 1: illegal-opcode trap flag.
- `state_o` out 3: current state encoding, debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: `imem_req_o`=1. On `mem_ready_i`: `ir_we_o`=1, `pc_we_o`=1, `pc_sel_o`=0, go to DECODE. Otherwise hold.
- DECODE: one cycle, no strobes. Opcode `instr_i[6:0]` in {0010011, 0110011, 0100011, 1100011, 0000011} goes to EXEC. Any other opcode is handled per Configuration.
- EXEC, I-ALU: `alu_src_o`=1, `alu_op_o`=10, go to WB.
- EXEC, R: `alu_src_o`=0, `alu_op_o`=10, go to WB.
- EXEC, L and S: `alu_src_o`=1, `alu_op_o`=00 (address), go to MEM.
- EXEC, B: `alu_src_o`=0, `alu_op_o`=01.
  - Taken when funct3=000 and `zero_i`=1, or funct3=001 and `zero_i`=0; all other funct3 are never taken.
  - Taken: `pc_we_o`=1, `pc_sel_o`=1. Go to FETCH either way.
- MEM, L: `dmem_re_o`=1 until `mem_ready_i`, then go to WB.
- MEM, S: `dmem_we_o`=1 until `mem_ready_i`, then go to FETCH.
- WB: `rf_we_o`=1; `wb_sel_o`=1 for L, 0 otherwise. Go to FETCH. rd=x0 is still written; the register file discards it.
- Wait counter (width `$clog2(WAIT_MAX)`):
  - Cleared on entering FETCH or MEM and whenever `mem_ready_i`=1.
  - Increments each cycle a request is pending without ready.
  - When count = `WAIT_MAX`-1 and still not ready: `timeout_o`=1 for one cycle and the request drops.
  - FETCH timeout: re-enter FETCH and retry the same PC (PC not updated).
  - MEM timeout: abandon the access, no register write, go to FETCH. PC already points to the next instruction.
- Ready and timeout on the same cycle: ready wins, no timeout.

## Timing
- Outputs are combinational from the registered state, registered opcode and funct3, `zero_i` and `mem_ready_i`. No output registers.
- While `rst_i`=1, every output strobe is forced to 0 and `state_o`=0. State resets to FETCH, counter to 0, `illegal_o` to 0.
- First fetch request appears in the first cycle after `rst_i` falls.
- Reset asserted mid-operation aborts immediately: pending requests drop in that cycle; nothing is written.
- Cycles per instruction with zero-wait memory (ready in the request cycle):
  - B: 3.
  - I, R, S: 4.
  - L: 5.
- Each memory wait cycle adds 1.
- Requests stay asserted and stable until ready or timeout; the controller never withdraws a request early except on timeout or reset.

## Configuration
- `AQRUI_ILLEGAL_TRAP_EN` defined:
  - An unrecognized opcode in DECODE enters TRAP.
  - TRAP: all strobes 0, `illegal_o`=1; the FSM remains in TRAP until `rst_i`.
- Not defined:
  - An unrecognized opcode is a NOP: DECODE goes to FETCH.
  - `illegal_o` is tied 0 and TRAP is unreachable.

## Structure
- Shared package `aqrui_pkg` holds:
  - the state enum;
  - opcode constants (OP_I, OP_R, OP_S, OP_B, OP_L);
  - `alu_op` encodings;
  - funct3 constants for BEQ/BNE.
- Sub-module `ctrl_opdecode` is combinational: opcode maps to a class one-hot plus a legal flag. It is shared by the FSM and the immediate-select logic.
- The FSM, wait counter and output decode stay in `multicycle_ctrl`.

## Test plan
- Reset, then zero-wait memory, fetch `add` (0x002081B3) → strobe sequence `imem_req` | `ir_we`+`pc_we`, DECODE, EXEC `alu_op`=10 `alu_src`=0, WB `rf_we`=1 `wb_sel`=0; back in FETCH at cycle 4.
- `lw` (0x0000A183) with `mem_ready_i` delayed 3 cycles in MEM → `dmem_re_o` high 4 cycles, then WB `wb_sel_o`=1; total 8 cycles.
- `beq` with `zero_i`=1 → EXEC `pc_we_o`=1, `pc_sel_o`=1. `bne` with `zero_i`=1 → no `pc_we_o`; both return to FETCH after 3 cycles.
- `sw` with `mem_ready_i` never asserted, `WAIT_MAX`=4 → `timeout_o` pulses on the 4th MEM cycle, no `rf_we_o`, next state FETCH.
- Opcode 0x7F with macro defined → `illegal_o`=1 and `state_o`=5 persist until `rst_i`. Without the macro → returns to FETCH and `illegal_o`=0.
- `rst_i` asserted during a `lw` MEM wait → `dmem_re_o` drops in the same cycle, `state_o`=0, and the next fetch follows reset release.
